fifo_bank: RTL and testbench

Parametrised bank of NUM_CH single-clock FIFOs sharing one packed write bus, with a per-channel write mask and independent per-channel reads. It generalises the fixed 4+1 lane FIFO grouping in front of the UKF datapath: one row of a matrix, or a diagonal element, is pushed in one cycle and drained lane by lane by the compute units. It adds occupancy counts, almost-full, and sticky overflow/underflow error flags.

---
 rtl/fifo_bank_pkg.sv | 15 +
 rtl/fifo_bank_ch.sv | 107 ++++++++++
 rtl/fifo_bank.sv | 54 +++++
 tb/tb_fifo_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bank_pkg.sv
// fifo_bank_pkg: shared default sizes for the FIFO bank and the helper that
// sizes an occupancy counter able to hold 0..depth inclusive.
package fifo_bank_pkg;

   localparam int FB_NUM_CH     = 5;
   localparam int FB_DATA_WIDTH = 32;
   localparam int FB_DEPTH      = 16;
   localparam int FB_AF_LEVEL   = 12;

   // Bits needed to represent the values 0..depth (a full FIFO needs depth itself).
   function automatic int clog2p1(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_bank_ch.sv
// fifo_bank_ch: one channel of the FIFO bank. Holds the storage, read/write
// pointers, occupancy count, registered status flags and sticky error bits.
// Build option FIFO_BANK_FWFT_EN selects first-word-fall-through reads;
// without it a read returns its word one cycle after the accepting edge.
module fifo_bank_ch
   import fifo_bank_pkg::*;
#(
   parameter int  DATA_WIDTH = FB_DATA_WIDTH,
   parameter int  DEPTH      = FB_DEPTH,
   parameter int  AF_LEVEL   = FB_AF_LEVEL,
   localparam int CW         = clog2p1(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_req,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [CW-1:0]         count,
   output logic                  ovf,
   output logic                  udf
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [CW-1:0]         count_nxt;

   // Accept decisions use the registered flags, i.e. the state before the edge.
   // A full channel drops the write even when a read frees a slot this cycle,
   // and an empty channel drops the read even when a write arrives this cycle.
   assign wr_acc = wr_req & ~full;
   assign rd_acc = rd_en & ~empty;

   // Next occupancy: simultaneous accepted read and write leave it unchanged.
   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Pointers, count, status flags and sticky errors; flags derive from count_nxt
   // so they line up with count in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         ovf         <= 1'b0;
         udf         <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         count       <= count_nxt;
         full        <= (count_nxt == CW'(DEPTH));
         empty       <= (count_nxt == '0);
         almost_full <= (count_nxt >= CW'(AF_LEVEL));
         // A fresh error in the clearing cycle keeps the flag set.
         ovf         <= (ovf & ~err_clr) | (wr_req & full);
         udf         <= (udf & ~err_clr) | (rd_en & empty);
      end
   end

   // Storage write; contents are intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

`ifdef FIFO_BANK_FWFT_EN
   // Head word is always presented; forced to zero while nothing is stored.
   assign rd_data  = empty ? '0 : mem[rd_ptr];
   assign rd_valid = ~empty;
`else
   logic [DATA_WIDTH-1:0] rd_data_p1;
   logic                  rd_vld_p1;

   // Stage p1: capture the head word on an accepted read; hold it otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_p1 <= '0;
         rd_vld_p1  <= 1'b0;
      end else begin
         rd_vld_p1 <= rd_acc;
         if (rd_acc) rd_data_p1 <= mem[rd_ptr];
      end
   end

   assign rd_data  = rd_data_p1;
   assign rd_valid = rd_vld_p1;
`endif

endmodule

// File: rtl/fifo_bank.sv
// fifo_bank: NUM_CH independent single-clock FIFOs sharing one packed write
// bus with a per-channel write mask, and with per-channel reads. The top only
// slices the packed buses and fans the masked write strobe out to channels.
// Build option FIFO_BANK_FWFT_EN switches every channel to first-word-fall-through.
module fifo_bank
   import fifo_bank_pkg::*;
#(
   parameter int  NUM_CH     = FB_NUM_CH,
   parameter int  DATA_WIDTH = FB_DATA_WIDTH,
   parameter int  DEPTH      = FB_DEPTH,
   parameter int  AF_LEVEL   = FB_AF_LEVEL,
   localparam int CW         = clog2p1(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [NUM_CH-1:0]            wr_mask,
   input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_CH-1:0]            rd_en,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_CH-1:0]            rd_valid,
   output logic [NUM_CH-1:0]            full,
   output logic [NUM_CH-1:0]            empty,
   output logic [NUM_CH-1:0]            almost_full,
   output logic [NUM_CH*CW-1:0]         count,
   input  logic                         err_clr,
   output logic                         [NUM_CH-1:0] ovf,
   output logic                         [NUM_CH-1:0] udf
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fifo_bank_ch #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .AF_LEVEL   (AF_LEVEL)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .wr_req      (wr_en & wr_mask[c]),
         .wr_data     (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .rd_en       (rd_en[c]),
         .err_clr     (err_clr),
         .rd_data     (rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .rd_valid    (rd_valid[c]),
         .full        (full[c]),
         .empty       (empty[c]),
         .almost_full (almost_full[c]),
         .count       (count[c*CW +: CW]),
         .ovf         (ovf[c]),
         .udf         (udf[c])
      );
   end

endmodule

// File: tb/tb_fifo_bank.sv
// tb_fifo_bank: self-checking bench for fifo_bank (default registered-read build).
// Reference model keeps one queue per channel and applies the accept rules directly.
module tb_fifo_bank;

   localparam int NCH   = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int CW    = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [NCH-1:0]    wr_mask;
   logic [NCH*DW-1:0] wr_data;
   logic [NCH-1:0]    rd_en;
   logic              err_clr;
   logic [NCH*DW-1:0] rd_data;
   logic [NCH-1:0]    rd_valid;
   logic [NCH-1:0]    full;
   logic [NCH-1:0]    empty;
   logic [NCH-1:0]    almost_full;
   logic [NCH*CW-1:0] count;
   logic [NCH-1:0]    ovf;
   logic [NCH-1:0]    udf;

   always #5 clk = ~clk;

   fifo_bank #(
      .NUM_CH     (NCH),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AFL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_mask     (wr_mask),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .err_clr     (err_clr),
      .ovf         (ovf),
      .udf         (udf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0]  mq [NCH][$];
   logic [DW-1:0]  m_rdd [NCH];
   logic [NCH-1:0] m_rdv;
   logic [NCH-1:0] m_ovf;
   logic [NCH-1:0] m_udf;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_update();
      int  sz;
      bit  wreq;
      for (int c = 0; c < NCH; c++) begin
         if (!rst_n) begin
            mq[c].delete();
            m_rdd[c] = '0;
            m_rdv[c] = 1'b0;
            m_ovf[c] = 1'b0;
            m_udf[c] = 1'b0;
         end else begin
            sz   = mq[c].size();
            wreq = wr_en && wr_mask[c];
            m_ovf[c] = (m_ovf[c] && !err_clr) || (wreq && sz == DEPTH);
            m_udf[c] = (m_udf[c] && !err_clr) || (rd_en[c] && sz == 0);
            m_rdv[c] = rd_en[c] && sz != 0;
            if (m_rdv[c]) m_rdd[c] = mq[c].pop_front();
            if (wreq && sz != DEPTH) mq[c].push_back(wr_data[c*DW +: DW]);
         end
      end
   endtask

   task automatic check_all();
      logic [NCH*DW-1:0] e_rdd;
      logic [NCH*CW-1:0] e_cnt;
      logic [NCH-1:0]    e_full, e_empty, e_af;
      for (int c = 0; c < NCH; c++) begin
         e_rdd[c*DW +: DW] = m_rdd[c];
         e_cnt[c*CW +: CW] = CW'(mq[c].size());
         e_full[c]  = (mq[c].size() == DEPTH);
         e_empty[c] = (mq[c].size() == 0);
         e_af[c]    = (mq[c].size() >= AFL);
      end
      chk("mdl.rd_valid", rd_valid, m_rdv);
      chk("mdl.rd_data", rd_data, e_rdd);
      chk("mdl.count", count, e_cnt);
      chk("mdl.full", full, e_full);
      chk("mdl.empty", empty, e_empty);
      chk("mdl.almost_full", almost_full, e_af);
      chk("mdl.ovf", ovf, m_ovf);
      chk("mdl.udf", udf, m_udf);
   endtask

   task automatic cycle(input logic r, input logic we, input logic [NCH-1:0] m,
                        input logic [NCH*DW-1:0] d, input logic [NCH-1:0] re, input logic clr);
      rst_n   = r;
      wr_en   = we;
      wr_mask = m;
      wr_data = d;
      rd_en   = re;
      err_clr = clr;
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   // Reset with every request asserted; reset must dominate.
   task automatic reset_and_check(input string tag);
      cycle(1'b0, 1'b1, '1, {5{32'hFFFF_0000}}, '1, 1'b0);
      chk({tag, ".count"}, count, 0);
      chk({tag, ".empty"}, empty, 5'h1F);
      chk({tag, ".full"}, full, 0);
      chk({tag, ".almost_full"}, almost_full, 0);
      chk({tag, ".rd_valid"}, rd_valid, 0);
      chk({tag, ".rd_data"}, rd_data, 0);
      chk({tag, ".ovf"}, ovf, 0);
      chk({tag, ".udf"}, udf, 0);
   endtask

   typedef struct {
      logic           we;
      logic [NCH-1:0] m;
      logic [NCH-1:0] re;
      logic           clr;
      logic [NCH*CW-1:0] e_cnt;
      logic [NCH-1:0] e_rdv;
      logic [DW-1:0]  e_d2;
      logic [NCH-1:0] e_udf;
   } vec_t;

   vec_t vt[5];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NCH*DW-1:0] pat;
      logic [NCH*DW-1:0] d;
      logic [NCH-1:0]    rp;
      int  wi, ri, guard;
      bit  over, dw_go, dr_go;

      pat = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      vt[0] = '{1'b1, 5'b11111, 5'b00000, 1'b0, {5'd1, 5'd1, 5'd1, 5'd1, 5'd1}, 5'b00000, 32'h0,         5'b00000};
      vt[1] = '{1'b0, 5'b00000, 5'b00100, 1'b0, {5'd1, 5'd1, 5'd0, 5'd1, 5'd1}, 5'b00100, 32'h3333_3333, 5'b00000};
      vt[2] = '{1'b0, 5'b00000, 5'b00000, 1'b0, {5'd1, 5'd1, 5'd0, 5'd1, 5'd1}, 5'b00000, 32'h3333_3333, 5'b00000};
      vt[3] = '{1'b0, 5'b00000, 5'b00100, 1'b0, {5'd1, 5'd1, 5'd0, 5'd1, 5'd1}, 5'b00000, 32'h3333_3333, 5'b00100};
      vt[4] = '{1'b0, 5'b00000, 5'b00000, 1'b1, {5'd1, 5'd1, 5'd0, 5'd1, 5'd1}, 5'b00000, 32'h3333_3333, 5'b00000};

      reset_and_check("rst0");

      // Table: write all lanes, read ch2, underflow and clear
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, vt[i].we, vt[i].m, pat, vt[i].re, vt[i].clr);
         chk($sformatf("vec%0d.count", i), count, vt[i].e_cnt);
         chk($sformatf("vec%0d.rd_valid", i), rd_valid, vt[i].e_rdv);
         chk($sformatf("vec%0d.rd_data2", i), rd_data[2*DW +: DW], vt[i].e_d2);
         chk($sformatf("vec%0d.udf", i), udf, vt[i].e_udf);
      end

      // Fill ch0: almost_full at 12, full at 16, 17th dropped
      reset_and_check("rst1");
      for (int i = 0; i < 16; i++) begin
         d = '0;
         d[DW-1:0] = 32'hF000_0000 + i;
         cycle(1'b1, 1'b1, 5'b00001, d, 5'b0, 1'b0);
         if (i == 10) chk("fill.af_at11", almost_full[0], 1'b0);
         if (i == 11) chk("fill.af_at12", almost_full[0], 1'b1);
         if (i == 14) chk("fill.full_at15", full[0], 1'b0);
         if (i == 15) chk("fill.full_at16", full[0], 1'b1);
      end
      cycle(1'b1, 1'b1, 5'b00001, {5{32'hBAD0_BAD0}}, 5'b0, 1'b0);
      chk("fill.ovf", ovf[0], 1'b1);
      chk("fill.count16", count[0 +: CW], 5'd16);

      // Full ch0 with write+read: read wins, write dropped
      cycle(1'b1, 1'b0, 5'b0, '0, 5'b0, 1'b1);
      chk("fullrw.ovf_cleared", ovf[0], 1'b0);
      cycle(1'b1, 1'b1, 5'b00001, {5{32'hDEAD_BEEF}}, 5'b00001, 1'b0);
      chk("fullrw.count15", count[0 +: CW], 5'd15);
      chk("fullrw.rd_valid", rd_valid[0], 1'b1);
      chk("fullrw.head", rd_data[0 +: DW], 32'hF000_0000);
      chk("fullrw.ovf", ovf[0], 1'b1);

      // Empty ch3 with write+read: write wins, read dropped
      d = '0;
      d[3*DW +: DW] = 32'hA5A5_A5A5;
      cycle(1'b1, 1'b1, 5'b01000, d, 5'b01000, 1'b0);
      chk("emptyrw.udf", udf[3], 1'b1);
      chk("emptyrw.count1", count[3*CW +: CW], 5'd1);
      chk("emptyrw.rd_valid", rd_valid[3], 1'b0);
      cycle(1'b1, 1'b0, 5'b0, '0, 5'b01000, 1'b0);
      chk("emptyrw.rd_valid2", rd_valid[3], 1'b1);
      chk("emptyrw.data", rd_data[3*DW +: DW], 32'hA5A5_A5A5);
      cycle(1'b1, 1'b0, 5'b0, '0, 5'b0, 1'b0);
      chk("emptyrw.pulse", rd_valid[3], 1'b0);
      chk("emptyrw.hold", rd_data[3*DW +: DW], 32'hA5A5_A5A5);

      // 40 words through ch1 across pointer wrap
      wi = 0; ri = 0; guard = 0; over = 1'b0;
      while ((wi < 40 || ri < 40) && guard < 1000) begin
         dw_go = (wi < 40) && (mq[1].size() < DEPTH) && ($urandom_range(0, 2) != 0);
         dr_go = (mq[1].size() > 0) && (($urandom_range(0, 1) == 1) || wi >= 40);
         d = '0;
         d[DW +: DW] = 32'hC0DE_0000 + wi;
         cycle(1'b1, dw_go, 5'b00010, d, dr_go ? 5'b00010 : 5'b0, 1'b0);
         if (dw_go) wi++;
         if (dr_go) begin
            chk("ch1.order", rd_data[DW +: DW], 32'hC0DE_0000 + ri);
            ri++;
         end
         if (count[CW +: CW] > DEPTH) over = 1'b1;
         guard++;
      end
      chk("ch1.drained", ri, 40);
      chk("ch1.cnt_le_depth", over, 1'b0);
      chk("ch1.no_ovf", ovf[1], 1'b0);
      chk("ch1.no_udf", udf[1], 1'b0);

      // err_clr with a new underflow on ch4: new error wins
      cycle(1'b1, 1'b0, 5'b0, '0, 5'b10000, 1'b0);
      chk("clr.udf4_set", udf[4], 1'b1);
      cycle(1'b1, 1'b0, 5'b0, '0, 5'b10000, 1'b1);
      chk("clr.udf4_kept", udf[4], 1'b1);
      chk("clr.udf3_cleared", udf[3], 1'b0);

      // Reset with 3 words queued discards them
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'b00100, {5{32'h7700_0000 + i}}, 5'b0, 1'b0);
      chk("q3.count", count[2*CW +: CW], 5'd3);
      reset_and_check("rst2");
      cycle(1'b1, 1'b0, 5'b0, '0, 5'b00100, 1'b0);
      chk("q3.after_rst_rdv", rd_valid[2], 1'b0);
      chk("q3.after_rst_udf", udf[2], 1'b1);

      // Randomized traffic against the model: fill-biased then drain-biased
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NCH; c++) begin
            d[c*DW +: DW] = $urandom;
            rp[c] = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         end
         cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), NCH'($urandom),
               d, rp, ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
